// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// The optional saturation feature is selected by SERIAL_ADDSUB_SAT_EN.
package serial_addsub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of digit cycles per operation.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width able to hold 0..N.
    function automatic int calc_cnt_w(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// DIGIT-bit ripple-carry slice; c_msb is the carry into the slice MSB, used
// by the parent to derive signed overflow on the final digit.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout_d,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign s_d[gi]       = a_d[gi] ^ b_d[gi] ^ carry[gi];
        assign carry[gi + 1] = (a_d[gi] & b_d[gi]) | (carry[gi] & (a_d[gi] ^ b_d[gi]));
    end

    assign cout_d = carry[DIGIT];
    assign c_msb  = carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor with start/busy/done handshake.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = calc_n(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT-1:0] s_d;
    logic             cout_d;
    logic             c_msb;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_shift;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d    (a_sh_reg[DIGIT-1:0]),
        .b_d    (b_sh_reg[DIGIT-1:0]),
        .cin    (carry_reg),
        .s_d    (s_d),
        .cout_d (cout_d),
        .c_msb  (c_msb)
    );

    assign ovf_d = c_msb ^ cout_d;

    // New digit enters from the MSB side so the LSB digit lands at bit 0 after N steps.
    if (DIGIT == WIDTH) begin : g_sum_single
        assign sum_shift = s_d;
    end else begin : g_sum_multi
        assign sum_shift = {s_d, sum_reg[WIDTH-1:DIGIT]};
    end

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b ^ {WIDTH{sub}};
                        carry_reg <= sub;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_reg  <= a_sh_reg >> DIGIT;
                    b_sh_reg  <= b_sh_reg >> DIGIT;
                    carry_reg <= cout_d;
                    sum_reg   <= sum_shift;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        cout_reg  <= cout_d;
                        ovf_reg   <= ovf_d;
`ifdef SERIAL_ADDSUB_SAT_EN
                        // On the last digit the bottom of a_sh_reg holds A's top digit.
                        if (ovf_d) begin
                            sum_reg <= a_sh_reg[DIGIT-1] ? SAT_MIN : SAT_MAX;
                        end
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
